// File: rtl/con_pkg.sv
// con_pkg: shared FSM state type, word width and button bit positions for
// the serial game-controller reader.
package con_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    FIRST,
    CLK_LO,
    CLK_HI,
    DONE
  } con_fsm_e;

  localparam int CON_BITS = 16;

  // Bit positions inside con_state, in controller shift order.
  localparam int B      = 0;
  localparam int Y      = 1;
  localparam int SELECT = 2;
  localparam int START  = 3;
  localparam int UP     = 4;
  localparam int DOWN   = 5;
  localparam int LEFT   = 6;
  localparam int RIGHT  = 7;
  localparam int A      = 8;
  localparam int X      = 9;
  localparam int L      = 10;
  localparam int R      = 11;

endpackage

// File: rtl/sync2.sv
// sync2: generic two-flop synchronizer for slow asynchronous inputs.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/con_reader.sv
// con_reader: drives the SNES-style latch/clock lines, shifts in 16 active-low
// button bits and publishes them as an active-high word, either periodically
// or on a one-shot request.
module con_reader
  import con_pkg::*;
#(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 150,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                poll_en,
  input  logic                poll_req,
  input  logic                con_data_in,
  output logic                con_latch_out,
  output logic                con_clk_out,
  output logic [CON_BITS-1:0] con_state,
  output logic                con_state_valid,
  output logic                busy
);

  localparam int TIMER_W = 20;
  localparam int CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(CON_BITS);

  // A poll interval shorter than one transaction would make every timer start
  // land while busy; the sync2 latency also needs a few cycles of each half.
  generate
    if ((POLL_CYCLES <= LATCH_CYCLES + 31 * HALF_CYCLES + 4) ||
        (POLL_CYCLES > (1 << TIMER_W)) || (HALF_CYCLES < 3) || (LATCH_CYCLES < 1)) begin : g_bad_params
      $error("con_reader: illegal LATCH_CYCLES/HALF_CYCLES/POLL_CYCLES combination");
    end
  endgenerate

  con_fsm_e            state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [CON_BITS-1:0] sh;
  logic [TIMER_W-1:0]  timer;
  logic                sync_data;
  logic                timer_hit;
  logic                start;
  logic                latch_done;
  logic                half_done;

  // Idle level is high (no button pressed), so the synchronizer resets to 1.
  sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (con_data_in),
    .q   (sync_data)
  );

  assign timer_hit  = poll_en && (timer == TIMER_W'(POLL_CYCLES - 1));
  assign start      = timer_hit || poll_req;
  assign latch_done = (cnt == CNT_W'(LATCH_CYCLES - 1));
  assign half_done  = (cnt == CNT_W'(HALF_CYCLES - 1));

  // Free-running poll interval timer; parked at zero while polling is disabled.
  always_ff @(posedge clk) begin
    if (rst || !poll_en) begin
      timer <= '0;
    end else if (timer_hit) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // Transaction sequencer; every output is registered and changes with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      sh              <= '0;
      con_latch_out   <= 1'b0;
      con_clk_out     <= 1'b1;
      con_state       <= '0;
      con_state_valid <= 1'b0;
      busy            <= 1'b0;
    end else begin
      con_state_valid <= 1'b0;
      cnt             <= cnt + CNT_W'(1);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state         <= LATCH;
            idx           <= '0;
            con_latch_out <= 1'b1;
            busy          <= 1'b1;
          end
        end
        LATCH: begin
          if (latch_done) begin
            state         <= FIRST;
            cnt           <= '0;
            con_latch_out <= 1'b0;
          end
        end
        FIRST: begin
          if (half_done) begin
            sh[0]       <= ~sync_data;
            idx         <= IDX_W'(1);
            state       <= CLK_LO;
            cnt         <= '0;
            con_clk_out <= 1'b0;
          end
        end
        CLK_LO: begin
          if (half_done) begin
            state       <= CLK_HI;
            cnt         <= '0;
            con_clk_out <= 1'b1;
          end
        end
        CLK_HI: begin
          if (half_done) begin
            sh[idx] <= ~sync_data;
            cnt     <= '0;
            if (idx == IDX_W'(CON_BITS - 1)) begin
              state <= DONE;
            end else begin
              idx         <= idx + IDX_W'(1);
              state       <= CLK_LO;
              con_clk_out <= 1'b0;
            end
          end
        end
        DONE: begin
          con_state       <= sh;
          con_state_valid <= 1'b1;
          busy            <= 1'b0;
          cnt             <= '0;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_con_reader.sv
// tb_con_reader: directed checks of con_reader against behavioural controller
// models, plus a second fast-timed instance for asynchronous data-edge sweeps.
module tb_con_reader;
  import con_pkg::*;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic        rst, poll_en, poll_req, con_data_in;
  logic        con_latch_out, con_clk_out, con_state_valid, busy;
  logic [15:0] con_state;

  logic        rst_f, poll_en_f, poll_req_f, con_data_in_f;
  logic        con_latch_out_f, con_clk_out_f, con_state_valid_f, busy_f;
  logic [15:0] con_state_f;

  logic [15:0] mask   = 16'h0000;
  logic [15:0] mask_f = 16'h0000;
  int          mbit   = 0;
  int          mbit_f = 0;

  int          valid_cnt, valid_cyc, latch_hi, lo_pulses, lo_run, lo_bad, overlap, busy_rises;
  logic        busy_at_valid;
  logic [15:0] last_state;
  int          vcyc_q[$];
  logic [15:0] vst_q[$];
  logic        prev_clk_out = 1'b1;
  logic        prev_busy    = 1'b0;
  logic [15:0] poll_masks[3] = '{16'hFFFF, 16'h0000, 16'h8001};

  con_reader #(
    .LATCH_CYCLES (600),
    .HALF_CYCLES  (150),
    .POLL_CYCLES  (8000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .poll_en         (poll_en),
    .poll_req        (poll_req),
    .con_data_in     (con_data_in),
    .con_latch_out   (con_latch_out),
    .con_clk_out     (con_clk_out),
    .con_state       (con_state),
    .con_state_valid (con_state_valid),
    .busy            (busy)
  );

  con_reader #(
    .LATCH_CYCLES (4),
    .HALF_CYCLES  (4),
    .POLL_CYCLES  (200)
  ) dut_f (
    .clk             (clk),
    .rst             (rst_f),
    .poll_en         (poll_en_f),
    .poll_req        (poll_req_f),
    .con_data_in     (con_data_in_f),
    .con_latch_out   (con_latch_out_f),
    .con_clk_out     (con_clk_out_f),
    .con_state       (con_state_f),
    .con_state_valid (con_state_valid_f),
    .busy            (busy_f)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Bench cycle count, one per rising edge.
  always @(posedge clk) cyc++;

  // Controller model: latch reloads bit 0, each rising clock shifts to the next bit.
  always @(posedge con_latch_out) mbit = 0;

  // Shift the main controller model on rising controller clock.
  always @(posedge con_clk_out) if (con_latch_out === 1'b0) mbit++;

  assign con_data_in = (mbit < 16) ? ~mask[mbit[3:0]] : 1'b0;

  // Same controller model for the fast instance.
  always @(posedge con_latch_out_f) mbit_f = 0;

  // Shift the fast controller model on rising controller clock.
  always @(posedge con_clk_out_f) if (con_latch_out_f === 1'b0) mbit_f++;

  assign con_data_in_f = (mbit_f < 16) ? ~mask_f[mbit_f[3:0]] : 1'b0;

  // Waveform monitor for the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (con_latch_out === 1'b1) latch_hi++;
    if (con_latch_out === 1'b1 && con_clk_out === 1'b0) overlap++;
    if (con_clk_out === 1'b0) lo_run++;
    if (prev_clk_out === 1'b1 && con_clk_out === 1'b0) lo_pulses++;
    if (prev_clk_out === 1'b0 && con_clk_out === 1'b1) begin
      if (lo_run != 150) lo_bad++;
      lo_run = 0;
    end
    if (busy === 1'b1 && prev_busy !== 1'b1) busy_rises++;
    if (con_state_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc     = cyc;
      last_state    = con_state;
      busy_at_valid = busy;
      vcyc_q.push_back(cyc);
      vst_q.push_back(con_state);
    end
    prev_clk_out = con_clk_out;
    prev_busy    = busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  task automatic clearMon();
    valid_cnt  = 0;
    latch_hi   = 0;
    lo_pulses  = 0;
    lo_run     = 0;
    lo_bad     = 0;
    overlap    = 0;
    busy_rises = 0;
    vcyc_q.delete();
    vst_q.delete();
  endtask

  // Load the controller mask and pulse poll_req; returns the cycle it was sampled.
  task automatic applyStimulus(input logic [15:0] m, output int req_cyc);
    mask = m;
    @(posedge clk); #1 poll_req = 1'b1;
    @(posedge clk); #1 poll_req = 1'b0;
    req_cyc = cyc;
  endtask

  task automatic waitValid(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && valid_cnt < target; i++) @(negedge clk);
    checkOutput({tag, "_seen"}, 32'(valid_cnt >= target), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic runMain();
    int req_cyc;
    int en_cyc;
    rst = 1'b1; poll_en = 1'b0; poll_req = 1'b0;
    clearMon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_latch", con_latch_out, 0);
    checkOutput("rst_clk", con_clk_out, 1);
    checkOutput("rst_state", con_state, 0);
    checkOutput("rst_valid", con_state_valid, 0);
    checkOutput("rst_busy", busy, 0);

    // Long idle with polling disabled: nothing may move.
    clearMon();
    repeat (10000) @(posedge clk);
    #1;
    checkOutput("idle_latch", con_latch_out, 0);
    checkOutput("idle_clk", con_clk_out, 1);
    checkOutput("idle_state", con_state, 0);
    checkOutput("idle_valid_cnt", valid_cnt, 0);
    checkOutput("idle_latch_hi", latch_hi, 0);

    // Single requested poll with a known button pattern.
    clearMon();
    applyStimulus(16'h0A05, req_cyc);
    checkOutput("req_busy_next", busy, 1);
    waitValid(1, 6000, "req");
    checkOutput("req_latency", valid_cyc - req_cyc, 5251);
    checkOutput("req_word", last_state, 16'h0A05);
    checkOutput("req_btn_X", con_state[X], 1);
    checkOutput("req_btn_Y", con_state[Y], 0);
    checkOutput("req_latch_len", latch_hi, 600);
    checkOutput("req_lo_pulses", lo_pulses, 15);
    checkOutput("req_lo_bad", lo_bad, 0);
    checkOutput("req_overlap", overlap, 0);
    checkOutput("req_busy_at_valid", busy_at_valid, 0);

    // Periodic polling with a changing controller pattern.
    clearMon();
    mask = poll_masks[0];
    poll_en = 1'b1;
    en_cyc = cyc;
    for (int n = 0; n < 3; n++) begin
      waitValid(n + 1, (n == 0) ? 14000 : 9000, "poll");
      if (n < 2) mask = poll_masks[n + 1];
    end
    checkOutput("poll_count", vcyc_q.size(), 3);
    if (vcyc_q.size() >= 3) begin
      checkOutput("poll_first", vcyc_q[0] - en_cyc, 13251);
      checkOutput("poll_gap1", vcyc_q[1] - vcyc_q[0], 8000);
      checkOutput("poll_gap2", vcyc_q[2] - vcyc_q[1], 8000);
      for (int n = 0; n < 3; n++) checkOutput($sformatf("poll_word%0d", n), vst_q[n], poll_masks[n]);
    end

    // poll_req coincident with timer expiry, then again mid-transaction.
    clearMon();
    mask = 16'h1234;
    while (cyc < en_cyc + 31999) begin
      @(posedge clk); #1;
    end
    poll_req = 1'b1;
    @(posedge clk); #1 poll_req = 1'b0;
    req_cyc = cyc;
    checkOutput("tie_busy", busy, 1);
    repeat (2000) @(posedge clk);
    #1 poll_req = 1'b1;
    @(posedge clk); #1 poll_req = 1'b0;
    repeat (500) @(posedge clk);
    #1 poll_en = 1'b0;
    waitValid(1, 4000, "tie");
    checkOutput("tie_latency", valid_cyc - req_cyc, 5251);
    checkOutput("tie_word", last_state, 16'h1234);
    repeat (6000) @(posedge clk);
    #1;
    checkOutput("tie_one_txn", valid_cnt, 1);
    checkOutput("tie_busy_rises", busy_rises, 1);
    checkOutput("tie_busy_end", busy, 0);
    checkOutput("hold_word", con_state, 16'h1234);

    // Reset during CLK_LO of bit 7 abandons the word.
    clearMon();
    applyStimulus(16'hBEEF, req_cyc);
    while (cyc < req_cyc + 2600) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_rst_clk_lo", con_clk_out, 0);
    checkOutput("pre_rst_state", con_state, 16'h1234);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_state", con_state, 0);
    checkOutput("abort_latch", con_latch_out, 0);
    checkOutput("abort_clk", con_clk_out, 1);
    checkOutput("abort_busy", busy, 0);
    rst = 1'b0;
    clearMon();
    applyStimulus(16'h5AC3, req_cyc);
    waitValid(1, 6000, "fresh");
    checkOutput("fresh_latency", valid_cyc - req_cyc, 5251);
    checkOutput("fresh_word", last_state, 16'h5AC3);
    checkOutput("fresh_lo_pulses", lo_pulses, 15);
  endtask

  // Data edges placed around each sample point on the fast instance.
  task automatic runJitter();
    logic [15:0] old_m, new_m, below, above, exp_m, keep, st;
    int          k, j;
    bit          seen;
    rst_f = 1'b1; poll_en_f = 1'b0; poll_req_f = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_f = 1'b0;
    for (int t = 0; t < 200; t++) begin
      old_m = 16'($urandom);
      new_m = 16'($urandom);
      k     = int'($urandom_range(0, 15));
      j     = int'($urandom_range(0, 2));
      mask_f = old_m;
      @(posedge clk); #1 poll_req_f = 1'b1;
      @(posedge clk); #1 poll_req_f = 1'b0;
      repeat (6 + 8 * k - j) @(posedge clk);
      #1 mask_f = new_m;
      seen = 1'b0;
      st   = '0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        if (con_state_valid_f === 1'b1) begin
          seen = 1'b1;
          st   = con_state_f;
        end
      end
      below = (16'h0001 << k) - 16'h0001;
      keep  = ~(16'h0001 << k);
      above = keep & ~below;
      exp_m = (old_m & below) | (new_m & above);
      checkOutput($sformatf("jit%0d_valid", t), 32'(seen), 32'd1);
      checkOutput($sformatf("jit%0d_word", t), st & keep, exp_m);
      checkOutput($sformatf("jit%0d_bit%0d", t, k),
                  32'((st[k] === old_m[k]) || (st[k] === new_m[k])), 32'd1);
    end
  endtask

  // Run both sequences side by side, then report.
  initial begin
    fork
      runMain();
      runJitter();
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit in case a fault stalls everything.
  initial begin
    #(95000 * 20);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
